// File: rtl/cpu_mem_responder_if.sv
// CPU-side control signals of the 2A03 memory bus.
// The data bus is bidirectional and stays a plain inout on the responder so the
// tristate driver resolves on an ordinary net rather than inside the interface.
interface cpu_mem_responder_if;
    logic       mem_rw;
    logic [7:0] mem_addr_l;
    logic [7:0] mem_addr_h;
    logic       cpu_rdy;

    modport master (
        output mem_rw,
        output mem_addr_l,
        output mem_addr_h,
        input  cpu_rdy
    );

    modport slave (
        input  mem_rw,
        input  mem_addr_l,
        input  mem_addr_h,
        output cpu_rdy
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the 2A03 CPU bus.
// Decodes the CPU address, serves 2^RAM_AW bytes of RAM mirrored over
// $0000-$1FFF, forwards $8000-$FFFF reads to the PRG port and, when the macro
// CPU_MEM_OAM_DMA_EN is defined, runs the OAM DMA engine triggered by a write
// to DMA_REG. Without the macro the CPU is never halted and the OAM port is idle.
//
// DMA states:
//   state | meaning
//   IDLE  | CPU owns the bus
//   HALT  | first halted cycle; picks ALIGN or RD from parity
//   ALIGN | extra cycle so the copy starts on the right parity
//   RD    | read {page, idx}, latch byte into the OAM data register
//   WR    | oam_we high; idx advances, ends after idx $FF
module cpu_mem_responder #(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_mem_responder_if.slave  bus,
    inout  wire  [7:0]          mem_data,
    output logic [14:0]         prg_addr,
    input  logic [7:0]          prg_rdata,
    output logic [7:0]          oam_addr,
    output logic [7:0]          oam_wdata,
    output logic                oam_we,
    output logic                dma_busy
);

    logic [15:0] cpu_addr;
    logic [15:0] acc_addr;
    logic [7:0]  rd_byte;
    logic        cpu_rdy_q;
    logic        cpu_wr;
    logic [7:0]  ram [2**RAM_AW];

    assign cpu_addr    = {bus.mem_addr_h, bus.mem_addr_l};
    assign cpu_wr      = rst_n && cpu_rdy_q && !bus.mem_rw;
    assign bus.cpu_rdy = cpu_rdy_q;
    assign prg_addr    = acc_addr[14:0];

`ifdef CPU_MEM_OAM_DMA_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} dma_state_t;

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;

    assign acc_addr = (state != IDLE) ? {page, idx} : cpu_addr;

    // Free-running toggle that decides whether the copy needs an align cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) parity <= 1'b0;
        else        parity <= ~parity;
    end

    // DMA sequencer; oam_wdata doubles as the byte buffer between RD and WR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            page      <= 8'h00;
            idx       <= 8'h00;
            cpu_rdy_q <= 1'b1;
            dma_busy  <= 1'b0;
            oam_we    <= 1'b0;
            oam_addr  <= 8'h00;
            oam_wdata <= 8'h00;
        end else begin
            oam_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wr && cpu_addr == DMA_REG) begin
                        page      <= mem_data;
                        state     <= HALT;
                        cpu_rdy_q <= 1'b0;
                        dma_busy  <= 1'b1;
                    end
                end
                HALT:  state <= parity ? ALIGN : RD;
                ALIGN: state <= RD;
                RD: begin
                    oam_we    <= 1'b1;
                    oam_addr  <= idx;
                    oam_wdata <= rd_byte;
                    state     <= WR;
                end
                WR: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state     <= IDLE;
                        cpu_rdy_q <= 1'b1;
                        dma_busy  <= 1'b0;
                    end else begin
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign acc_addr  = cpu_addr;
    assign cpu_rdy_q = 1'b1;
    assign dma_busy  = 1'b0;
    assign oam_we    = 1'b0;
    assign oam_addr  = 8'h00;
    assign oam_wdata = 8'h00;
`endif

    // Address decode shared by CPU reads and DMA reads.
    always_comb begin
        rd_byte = 8'h00;
        if (acc_addr == DMA_REG)
            rd_byte = 8'h00;
        else if (acc_addr[15:13] == 3'b000)
            rd_byte = ram[acc_addr[RAM_AW-1:0]];
        else if (acc_addr[15])
            rd_byte = prg_rdata;
    end

    // Mirrored RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (cpu_wr && cpu_addr[15:13] == 3'b000 && cpu_addr != DMA_REG)
            ram[cpu_addr[RAM_AW-1:0]] <= mem_data;
    end

    assign mem_data = (cpu_rdy_q && bus.mem_rw && rst_n) ? rd_byte : 8'hzz;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder. A transaction-level model (RAM array, DMA as a
// halt window with a fixed length and a pulse schedule) is compared against the
// DUT every cycle; directed steps add literal expectations.
module tb_cpu_mem_responder;

`ifdef CPU_MEM_OAM_DMA_EN
    localparam bit DMA_EN   = 1'b1;
    localparam int EXP_EVEN = 513;
    localparam int EXP_ODD  = 514;
    localparam int EXP_WE   = 256;
    localparam int EXP_MID  = 100;
`else
    localparam bit DMA_EN   = 1'b0;
    localparam int EXP_EVEN = 0;
    localparam int EXP_ODD  = 0;
    localparam int EXP_WE   = 0;
    localparam int EXP_MID  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    wire  [7:0]  mem_data;
    logic        drv_en;
    logic [7:0]  drv_val;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata;
    logic        prg_ovr_en;
    logic [7:0]  prg_fixed;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_busy;

    cpu_mem_responder_if bus ();

    always #5 clk = ~clk;

    assign mem_data  = drv_en ? drv_val : 8'hzz;
    assign prg_rdata = prg_ovr_en ? prg_fixed : (prg_addr[7:0] ^ 8'h96);

    cpu_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_data  (mem_data),
        .prg_addr  (prg_addr),
        .prg_rdata (prg_rdata),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .dma_busy  (dma_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cnt_rdy_low = 0;
    int cnt_we = 0;
    logic [7:0] last_oam_addr = 8'h00;
    logic [7:0] last_oam_wdata = 8'h00;
    logic [7:0] cap37 = 8'h00;

    // ---------------- model ----------------
    logic [7:0] mram [2048];
    bit         mvalid [2048];
    bit         m_live = 1'b0;
    bit         m_par = 1'b0;
    bit         m_dma_on = 1'b0;
    int         m_j = 0;
    int         m_L = 0;
    logic [7:0] m_page = 8'h00;

    always @(posedge clk) begin : model
        logic [15:0] a;
        a = {bus.mem_addr_h, bus.mem_addr_l};
        m_live = 1'b1;
        if (!rst_n) begin
            m_par    = 1'b0;
            m_dma_on = 1'b0;
        end else begin
            m_par = ~m_par;
            if (m_dma_on) begin
                m_j++;
                if (m_j > m_L) m_dma_on = 1'b0;
            end else if (!bus.mem_rw) begin
                if (a < 16'h2000) begin
                    mram[a[10:0]]   = mem_data;
                    mvalid[a[10:0]] = 1'b1;
                end else if (a == 16'h4014 && DMA_EN) begin
                    m_dma_on = 1'b1;
                    m_j      = 1;
                    m_L      = m_par ? 514 : 513;
                    m_page   = mem_data;
                end
            end
        end
    end

    function automatic logic [7:0] mdl_read(input logic [15:0] a);
        if (a == 16'h4014) return 8'h00;
        if (a < 16'h2000)  return mram[a[10:0]];
        if (a[15])         return prg_ovr_en ? prg_fixed : (a[7:0] ^ 8'h96);
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        logic [15:0] ca;
        logic [15:0] da;
        int          start;
        int          m;
        bit          exp_we;
        if (!m_live) return;
        ca     = {bus.mem_addr_h, bus.mem_addr_l};
        start  = m_L - 512;
        m      = m_j - start - 1;
        exp_we = m_dma_on && (m_j > start) && (m % 2 == 1);
        da     = {m_page, 8'(m / 2)};
        chk("cpu_rdy", 16'(bus.cpu_rdy), 16'(!m_dma_on));
        chk("dma_busy", 16'(dma_busy), 16'(m_dma_on));
        chk("oam_we", 16'(oam_we), 16'(exp_we));
        if (exp_we) begin
            chk("oam_addr", 16'(oam_addr), 16'(da[7:0]));
            chk("oam_wdata", 16'(oam_wdata), 16'(mdl_read(da)));
            last_oam_addr  = oam_addr;
            last_oam_wdata = oam_wdata;
            if (da[7:0] == 8'h37) cap37 = oam_wdata;
        end
        if (bus.cpu_rdy === 1'b0) cnt_rdy_low++;
        if (oam_we === 1'b1) cnt_we++;
        if (!m_dma_on)
            chk("prg_addr_cpu", 16'(prg_addr), 16'(ca[14:0]));
        else if (m_j > start && m % 2 == 0)
            chk("prg_addr_dma", 16'(prg_addr), 16'(da[14:0]));
        if (rst_n && !m_dma_on && bus.mem_rw && !drv_en && (ca >= 16'h2000 || mvalid[ca[10:0]]))
            chk("mem_data_rd", 16'(mem_data), 16'(mdl_read(ca)));
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic park();
        bus.mem_rw     = 1'b1;
        bus.mem_addr_h = 8'h50;
        bus.mem_addr_l = 8'h00;
        drv_en         = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.mem_rw = 1'b0;
        {bus.mem_addr_h, bus.mem_addr_l} = a;
        drv_en  = 1'b1;
        drv_val = d;
        tick();
        park();
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        bus.mem_rw = 1'b1;
        {bus.mem_addr_h, bus.mem_addr_l} = a;
        drv_en = 1'b0;
        tick();
        d = mem_data;
    endtask

    task automatic run_dma(input logic [7:0] pg, input bit par_halt, input int exp_low, input string tag);
        int low0;
        int we0;
        int w;
        w = 0;
        while (m_par == par_halt && w < 4) begin
            tick();
            w++;
        end
        low0 = cnt_rdy_low;
        we0  = cnt_we;
        cpu_write(16'h4014, pg);
        repeat (600) tick();
        chk($sformatf("%s_halt_len", tag), 16'(cnt_rdy_low - low0), 16'(exp_low));
        chk($sformatf("%s_we_pulses", tag), 16'(cnt_we - we0), 16'(EXP_WE));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] d;
        int we0;
        int k;

        rst_n      = 1'b0;
        drv_en     = 1'b1;
        drv_val    = 8'h00;
        bus.mem_rw = 1'b1;
        bus.mem_addr_h = 8'hC0;
        bus.mem_addr_l = 8'h00;
        prg_ovr_en = 1'b1;
        prg_fixed  = 8'hFF;
        tick();
        tick();
        chk("hiz_in_reset", 16'(mem_data), 16'h0000);
        chk("rst_cpu_rdy", 16'(bus.cpu_rdy), 16'h0001);
        chk("rst_dma_busy", 16'(dma_busy), 16'h0000);
        chk("rst_oam_we", 16'(oam_we), 16'h0000);
        chk("rst_oam_addr", 16'(oam_addr), 16'h0000);
        chk("rst_oam_wdata", 16'(oam_wdata), 16'h0000);

        park();
        prg_ovr_en = 1'b0;
        rst_n = 1'b1;
        tick();

        cpu_write(16'h0005, 8'hA5);
        cpu_read(16'h0805, d);
        chk("ram_mirror_0805", 16'(d), 16'h00A5);
        cpu_read(16'h1805, d);
        chk("ram_mirror_1805", 16'(d), 16'h00A5);
        cpu_write(16'h0123, 8'h11);

        prg_ovr_en = 1'b1;
        prg_fixed  = 8'h3C;
        cpu_read(16'hC123, d);
        chk("prg_addr_C123", 16'(prg_addr), 16'h4123);
        chk("prg_read_C123", 16'(d), 16'h003C);
        bus.mem_rw = 1'b0;
        drv_en  = 1'b1;
        drv_val = 8'h00;
        tick();
        chk("hiz_on_write", 16'(mem_data), 16'h0000);
        park();
        cpu_write(16'hC123, 8'h77);
        prg_ovr_en = 1'b0;
        cpu_read(16'h0123, d);
        chk("prg_write_ignored", 16'(d), 16'h0011);

        cpu_read(16'h5000, d);
        chk("unmapped_5000", 16'(d), 16'h0000);
        cpu_read(16'h4014, d);
        chk("dma_reg_read", 16'(d), 16'h0000);

        for (int i = 0; i < 256; i++)
            cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);

        run_dma(8'h02, 1'b0, EXP_EVEN, "even");
        if (DMA_EN) begin
            chk("even_last_addr", 16'(last_oam_addr), 16'h00FF);
            chk("even_last_wdata", 16'(last_oam_wdata), 16'h00A5);
            chk("even_wdata_37", 16'(cap37), 16'h006D);
        end
        run_dma(8'h02, 1'b1, EXP_ODD, "odd");
        run_dma(8'h40, 1'b0, EXP_EVEN, "page40");
        run_dma(8'h90, 1'b1, EXP_ODD, "prgpage");

        we0 = cnt_we;
        cpu_write(16'h4014, 8'h02);
        k = 0;
        while (cnt_we - we0 < EXP_MID && k < 400) begin
            tick();
            k++;
        end
        chk("midrst_reach", 16'(cnt_we - we0), 16'(EXP_MID));
        rst_n = 1'b0;
        tick();
        chk("midrst_cpu_rdy", 16'(bus.cpu_rdy), 16'h0001);
        chk("midrst_dma_busy", 16'(dma_busy), 16'h0000);
        chk("midrst_oam_we", 16'(oam_we), 16'h0000);
        rst_n = 1'b1;
        repeat (600) tick();
        chk("midrst_no_more_we", 16'(cnt_we - we0), 16'(EXP_MID));
        cpu_read(16'h0205, d);
        chk("ram_kept_0205", 16'(d), 16'h005F);
        cpu_read(16'h0005, d);
        chk("ram_kept_0005", 16'(d), 16'h00A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
